// File: rtl/j1b_uart_pkg.sv
// Shared definitions for the j1b UART receive path: FSM states, I/O map addresses
// and the default bit period.
package j1b_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam logic [15:0] UART_RX_ADDR = 16'h1000;
    localparam logic [15:0] MISC_IN_ADDR = 16'h2000;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;

endpackage

// File: rtl/j1b_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO. The head byte is read combinationally
// from the storage registers, so it only changes on clock edges.
module j1b_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [7:0]             data_i,
    input  logic                   pop_i,
    output logic [7:0]             data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [LW-1:0] level_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));

    // A pop frees the head slot during the same edge, so a full FIFO can still accept.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/j1b_uart_rx.sv
// 8N1 serial receiver for the j1b CPU UART read port, buffering received bytes in a
// FWFT FIFO whose head and non-empty status are presented to the CPU.
module j1b_uart_rx
    import j1b_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                   clk,
    input  logic                   resetq,
    input  logic                   rx,
    input  logic                   uart0_rd,
    output logic                   uart0_valid,
    output logic [7:0]             uart0_data,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   overrun,
    output logic                   frame_err,
    input  logic                   err_clr
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [1:0]      sync_q;
    logic            rx_s;
    rx_state_t       state_q;
    logic [CntW-1:0] baud_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            overrun_q;
    logic            frame_err_q;

    logic            stop_pt;
    logic            push_req;
    logic            frame_set;
    logic            ovr_set;
    logic            fifo_full;
    logic            fifo_empty;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], rx};
    end
    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            baud_q <= baud_q + CntW'(1);
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (!rx_s) state_q <= START;
                end
                START: begin
                    if (baud_q == HalfCnt) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (baud_q == LastCnt) begin
                        baud_q  <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end
                end
                STOP: begin
                    if (baud_q == LastCnt) begin
                        baud_q  <= '0;
                        state_q <= rx_s ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    baud_q <= '0;
                    if (rx_s) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The byte is written into the FIFO on the same edge that samples the stop bit.
    assign stop_pt   = (state_q == STOP) && (baud_q == LastCnt);
    assign push_req  = stop_pt & rx_s;
    assign frame_set = stop_pt & ~rx_s;
    assign ovr_set   = push_req & fifo_full & ~uart0_rd;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= ovr_set | (overrun_q & ~err_clr);
            frame_err_q <= frame_set | (frame_err_q & ~err_clr);
        end
    end

    j1b_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (resetq),
        .push_i  (push_req),
        .data_i  (shift_q),
        .pop_i   (uart0_rd),
        .data_o  (uart0_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (rx_level)
    );

    assign uart0_valid = ~fifo_empty;
    assign overrun     = overrun_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_j1b_uart_rx.sv
// Bench for j1b_uart_rx: a byte-queue model of the receive buffer checked every cycle,
// plus literal expectations for each scenario.
module tb_j1b_uart_rx;

    localparam int CPB   = 8;
    localparam int DEPTH = 16;

    logic       clk;
    logic       resetq;
    logic       rx;
    logic       uart0_rd;
    logic       uart0_valid;
    logic [7:0] uart0_data;
    logic [4:0] rx_level;
    logic       overrun;
    logic       frame_err;
    logic       err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: the bench announces each stop-bit sample cycle through evt.
    logic [7:0] mq[$];
    logic       m_ovr;
    logic       m_ferr;
    logic       evt;
    logic       evt_good;
    logic [7:0] evt_byte;

    j1b_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk         (clk),
        .resetq      (resetq),
        .rx          (rx),
        .uart0_rd    (uart0_rd),
        .uart0_valid (uart0_valid),
        .uart0_data  (uart0_data),
        .rx_level    (rx_level),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        forever begin
            @(posedge clk or negedge resetq);
            if (!resetq) begin
                mq.delete();
                m_ovr  = 1'b0;
                m_ferr = 1'b0;
            end else begin
                if (err_clr) begin
                    m_ovr  = 1'b0;
                    m_ferr = 1'b0;
                end
                if (uart0_rd && mq.size() > 0) void'(mq.pop_front());
                if (evt) begin
                    if (!evt_good)              m_ferr = 1'b1;
                    else if (mq.size() < DEPTH) mq.push_back(evt_byte);
                    else                        m_ovr = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cyc_valid", 32'(uart0_valid), 32'(mq.size() != 0));
            check("cyc_data", 32'(uart0_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
            check("cyc_level", 32'(rx_level), 32'(mq.size()));
            check("cyc_overrun", 32'(overrun), 32'(m_ovr));
            check("cyc_frame_err", 32'(frame_err), 32'(m_ferr));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [7:0] b, input bit stop_low, input bit rd_at_stop);
        int k;
        for (int c = 0; c < 10 * CPB; c++) begin
            k = c / CPB;
            if (k == 0)      rx = 1'b0;
            else if (k < 9)  rx = b[k-1];
            else             rx = ~stop_low;
            if (c == 10 * CPB - 1) begin
                evt      = 1'b1;
                evt_good = ~stop_low;
                evt_byte = b;
                if (rd_at_stop) uart0_rd = 1'b1;
            end
            @(posedge clk); #1;
        end
        evt      = 1'b0;
        uart0_rd = 1'b0;
        if (stop_low) begin
            repeat (19 * CPB) begin
                @(posedge clk); #1;
            end
            rx = 1'b1;
        end
    endtask

    task automatic pop();
        uart0_rd = 1'b1;
        @(posedge clk); #1;
        uart0_rd = 1'b0;
    endtask

    task automatic clr_flags();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic at_negedge();
        @(negedge clk);
    endtask

    task automatic realign();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] abort_b;
        int k;
        resetq   = 1'b0;
        rx       = 1'b1;
        uart0_rd = 1'b0;
        err_clr  = 1'b0;
        evt      = 1'b0;
        evt_good = 1'b1;
        evt_byte = 8'h00;
        idle(3);
        at_negedge();
        check("reset_valid", 32'(uart0_valid), 32'h0);
        check("reset_data", 32'(uart0_data), 32'h0);
        check("reset_level", 32'(rx_level), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        realign();
        resetq = 1'b1;
        idle(2 * CPB);

        // Single byte: visible on the cycle after the stop sample.
        send(8'h55, 1'b0, 1'b0);
        at_negedge();
        check("single_valid", 32'(uart0_valid), 32'h1);
        check("single_data", 32'(uart0_data), 32'h55);
        realign();
        pop();
        at_negedge();
        check("single_valid_after_rd", 32'(uart0_valid), 32'h0);
        check("single_level_after_rd", 32'(rx_level), 32'h0);
        realign();

        // Back-to-back frames into a full FIFO: last byte dropped.
        for (int i = 0; i <= 16; i++) send(8'(i), 1'b0, 1'b0);
        at_negedge();
        check("ovr_level", 32'(rx_level), 32'd16);
        check("ovr_flag", 32'(overrun), 32'h1);
        realign();
        for (int i = 0; i < 16; i++) begin
            at_negedge();
            check("ovr_order", 32'(uart0_data), 32'(i));
            realign();
            pop();
        end
        at_negedge();
        check("ovr_drained", 32'(uart0_valid), 32'h0);
        realign();
        clr_flags();
        at_negedge();
        check("ovr_cleared", 32'(overrun), 32'h0);
        realign();

        // Framing error: long break then a good byte.
        send(8'hA3, 1'b1, 1'b0);
        at_negedge();
        check("ferr_flag", 32'(frame_err), 32'h1);
        check("ferr_no_push", 32'(rx_level), 32'h0);
        realign();
        idle(2 * CPB);
        send(8'h3C, 1'b0, 1'b0);
        at_negedge();
        check("ferr_level", 32'(rx_level), 32'h1);
        check("ferr_data", 32'(uart0_data), 32'h3C);
        realign();
        pop();
        clr_flags();
        at_negedge();
        check("ferr_cleared", 32'(frame_err), 32'h0);
        realign();

        // Glitch shorter than half a bit is rejected.
        rx = 1'b0;
        idle(CPB / 2 - 2);
        rx = 1'b1;
        idle(3 * CPB);
        at_negedge();
        check("glitch_level", 32'(rx_level), 32'h0);
        check("glitch_overrun", 32'(overrun), 32'h0);
        check("glitch_frame_err", 32'(frame_err), 32'h0);
        realign();

        // Simultaneous push and pop at full.
        for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b0, 1'b0);
        send(8'h30, 1'b0, 1'b1);
        at_negedge();
        check("simul_level", 32'(rx_level), 32'd16);
        check("simul_overrun", 32'(overrun), 32'h0);
        check("simul_head", 32'(uart0_data), 32'h21);
        realign();
        for (int i = 0; i < 16; i++) begin
            at_negedge();
            check("simul_order", 32'(uart0_data), 32'h21 + 32'(i));
            realign();
            pop();
        end
        pop();
        at_negedge();
        check("empty_rd_level", 32'(rx_level), 32'h0);
        check("empty_rd_valid", 32'(uart0_valid), 32'h0);
        realign();
        idle(4);
        send(8'h5A, 1'b0, 1'b0);
        at_negedge();
        check("after_empty_rd_data", 32'(uart0_data), 32'h5A);
        check("after_empty_rd_level", 32'(rx_level), 32'h1);
        realign();

        // Reset in the middle of DATA bit 4 of 0xF0, with a byte already queued.
        abort_b = 8'hF0;
        for (int c = 0; c < 4 * CPB + CPB + CPB / 2; c++) begin
            k = c / CPB;
            rx = (k == 0) ? 1'b0 : abort_b[k-1];
            @(posedge clk); #1;
        end
        resetq = 1'b0;
        rx     = 1'b1;
        at_negedge();
        check("rst_mid_valid", 32'(uart0_valid), 32'h0);
        check("rst_mid_data", 32'(uart0_data), 32'h0);
        check("rst_mid_level", 32'(rx_level), 32'h0);
        realign();
        idle(2);
        resetq = 1'b1;
        idle(CPB);
        send(8'h81, 1'b0, 1'b0);
        at_negedge();
        check("rst_mid_rx_level", 32'(rx_level), 32'h1);
        check("rst_mid_rx_data", 32'(uart0_data), 32'h81);
        realign();
        pop();
        idle(3 * CPB);
        at_negedge();
        check("rst_mid_final_level", 32'(rx_level), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
